// File: rtl/dsd_pkg.sv
// dsd_pkg: shared constants and helpers for the DSD tap engine.
// Rate encoding, silence byte and the rate-to-divisor mapping.
package dsd_pkg;

   localparam logic [1:0] RATE_DSD64  = 2'd0;
   localparam logic [1:0] RATE_DSD128 = 2'd1;
   localparam logic [1:0] RATE_DSD256 = 2'd2;
   localparam logic [1:0] RATE_DSD512 = 2'd3;

   localparam logic [7:0] MUTE_BYTE = 8'h69;

   function automatic logic [3:0] dsd_div(input logic [1:0] rate);
      logic [3:0] d;
      d = 4'd8;
      unique case (rate)
         RATE_DSD64:  d = 4'd8;
         RATE_DSD128: d = 4'd4;
         RATE_DSD256: d = 4'd2;
         RATE_DSD512: d = 4'd1;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/dsd_tap_line.sv
// dsd_tap_line: one channel's word shifter and FIR tap delay line.
// Taps are presented with optional polarity inversion.
module dsd_tap_line
   import dsd_pkg::*;
#(
   parameter int TAPS = 8,
   parameter int WORD = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic [WORD-1:0] load_word,
   input  logic            tick,
   input  logic            mute_bit,
   input  logic            mute,
   input  logic            invert,
   output logic [TAPS-1:0] tap_out
);

   logic [WORD-1:0] shifter;
   logic [TAPS-1:0] taps;
   logic            in_bit;

   assign in_bit  = mute ? mute_bit : shifter[WORD-1];
   assign tap_out = taps ^ {TAPS{invert}};

   // word shifter: reload wins over shift, MSB goes out first
   always_ff @(posedge clk) begin
      if (reset)
         shifter <= '0;
      else if (load)
         shifter <= load_word;
      else if (tick)
         shifter <= {shifter[WORD-2:0], 1'b0};
   end

   // delay line: tap k lags tap 0 by k ticks
   always_ff @(posedge clk) begin
      if (reset) begin
         taps <= '0;
      end else if (tick) begin
         taps[0] <= in_bit;
         for (int k = 1; k < TAPS; k++)
            taps[k] <= taps[k-1];
      end
   end

endmodule

// File: rtl/dsd_tap_engine.sv
// dsd_tap_engine: CHANNELS x TAPS DSD output engine with hold buffer.
// FSM, rate divider, bit counter and complementary pin drive.
module dsd_tap_engine
   import dsd_pkg::*;
#(
   parameter int CHANNELS = 2,
   parameter int TAPS     = 8,
   parameter int WORD     = 32
) (
   input  logic                     mclk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic [1:0]               rate_sel,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [CHANNELS*WORD-1:0] in_data,
   input  logic                     mute,
   input  logic                     invert,
   output logic [CHANNELS*TAPS-1:0] dsd_p,
   output logic [CHANNELS*TAPS-1:0] dsd_n,
   output logic                     bit_strobe,
   output logic                     underrun,
   output logic                     running
);

   localparam int BW = $clog2(WORD);
   localparam int NB = CHANNELS * WORD / 8;
   localparam logic [BW-1:0] LAST = BW'(WORD - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   logic [1:0]               state;
   logic [1:0]               rate_q;
   logic [2:0]               div_q;
   logic [BW-1:0]            bit_cnt;
   logic                     hold_full;
   logic [CHANNELS*WORD-1:0] hold_word;
   logic [CHANNELS*WORD-1:0] silence;
   logic [CHANNELS*WORD-1:0] load_word;
   logic [3:0]               div_n;
   logic active, tick, last_bit, start, bnd;
   logic drain_done, load, use_hold, accept, mute_bit;

   assign div_n      = dsd_div(rate_q);
   assign active     = (state != S_IDLE);
   assign tick       = active && ({1'b0, div_q} == div_n - 4'd1);
   assign last_bit   = tick && (bit_cnt == LAST);
   assign start      = (state == S_IDLE) && enable && hold_full;
   assign bnd        = last_bit && (state == S_RUN);
   assign drain_done = last_bit && (state == S_DRAIN);
   assign load       = start || bnd;
   assign use_hold   = start || (bnd && hold_full);
   assign accept     = in_valid && in_ready;
   assign silence    = {NB{MUTE_BYTE}};
   assign load_word  = use_hold ? hold_word : silence;
   assign mute_bit   = MUTE_BYTE[3'd7 - bit_cnt[2:0]];

   assign in_ready = ~hold_full;
   assign underrun = bnd && !hold_full;
   assign running  = active;

   // run state machine; DRAIN only exits to IDLE
   always_ff @(posedge mclk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         unique case (state)
            S_IDLE:  if (start) state <= S_RUN;
            S_RUN:   if (!enable) state <= S_DRAIN;
            S_DRAIN: if (drain_done) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // rate divider and bit counter, restarted on every word load
   always_ff @(posedge mclk) begin
      if (reset) begin
         div_q   <= '0;
         bit_cnt <= '0;
         rate_q  <= RATE_DSD64;
      end else if (load) begin
         div_q   <= '0;
         bit_cnt <= '0;
         rate_q  <= rate_sel;
      end else if (!active) begin
         div_q   <= '0;
         bit_cnt <= '0;
      end else if (tick) begin
         div_q   <= '0;
         bit_cnt <= (bit_cnt == LAST) ? '0 : bit_cnt + 1'b1;
      end else begin
         div_q   <= div_q + 3'd1;
      end
   end

   // hold buffer occupancy; fill and drain never coincide
   always_ff @(posedge mclk) begin
      if (reset)
         hold_full <= 1'b0;
      else if (accept)
         hold_full <= 1'b1;
      else if (use_hold)
         hold_full <= 1'b0;
   end

   // hold buffer data capture
   always_ff @(posedge mclk) begin
      if (accept)
         hold_word <= in_data;
   end

   // strobe marks the cycle after each tap update
   always_ff @(posedge mclk) begin
      if (reset)
         bit_strobe <= 1'b0;
      else
         bit_strobe <= tick && !drain_done;
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [TAPS-1:0] taps;

      dsd_tap_line #(
         .TAPS (TAPS),
         .WORD (WORD)
      ) u_line (
         .clk       (mclk),
         .reset     (reset || drain_done),
         .load      (load),
         .load_word (load_word[c*WORD +: WORD]),
         .tick      (tick),
         .mute_bit  (mute_bit),
         .mute      (mute),
         .invert    (invert),
         .tap_out   (taps)
      );

      assign dsd_p[c*TAPS +: TAPS] = active ? taps  : '0;
      assign dsd_n[c*TAPS +: TAPS] = active ? ~taps : '0;
   end

endmodule
